ic_cpu_bus_arbiter: RTL and testbench

//  2:1 arbiter sharing one CPU request/response bus port (the input of a

---
 rtl/ic_cpu_bus_arbiter_pkg.sv | 42 ++++
 rtl/ic_cpu_bus_arbiter_id_fifo.sv | 71 +++++++
 rtl/ic_cpu_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_ic_cpu_bus_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ic_cpu_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : ic_cpu_bus_arbiter_pkg
// | Brief    : Shared constants, request bundle and arbitration helper.
// | Revision : 1.0
// +----------------------------------------------------------------------------
package ic_cpu_bus_arbiter_pkg;

  localparam int   IC_ARB_RR    = 0;
  localparam int   IC_ARB_FIXED = 1;
  localparam logic IC_ID_INSTR  = 1'b0;
  localparam logic IC_ID_DATA   = 1'b1;

  typedef struct packed {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
  } ic_req_t;

  // Arbiter lock state: HELD keeps the downstream request stable until granted.
  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_HELD = 1'b1
  } arb_state_t;

  function automatic logic ic_arb_pick(input logic req0, input logic req1,
                                       input logic last_id, input int mode);
    logic pick;
    pick = IC_ID_INSTR;
    if (req0 && !req1) begin
      pick = IC_ID_INSTR;
    end else if (!req0 && req1) begin
      pick = IC_ID_DATA;
    end else if (req0 && req1) begin
      pick = (mode == IC_ARB_FIXED) ? IC_ID_DATA : ~last_id;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ic_cpu_bus_arbiter_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : ic_id_fifo
// | Brief    : In-order owner-ID queue for outstanding bus transactions.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module ic_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             g_clk,
  input  logic             g_resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] ptr);
    return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_W'(1);
  endfunction

  assign full    = (r_count == c_CNT_FULL);
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ic_cpu_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : ic_cpu_bus_arbiter
// | Brief    : 2:1 arbiter sharing one CPU bus port between instr and data.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module ic_cpu_bus_arbiter
  import ic_cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PRIORITY_MODE   = IC_ARB_RR
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        m0_req,
  output logic        m0_gnt,
  input  logic        m0_wen,
  input  logic [3:0]  m0_strb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic        m0_recv,
  input  logic        m0_ack,
  output logic        m0_error,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  output logic        m1_gnt,
  input  logic        m1_wen,
  input  logic [3:0]  m1_strb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic        m1_recv,
  input  logic        m1_ack,
  output logic        m1_error,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  input  logic        s_gnt,
  output logic        s_wen,
  output logic [3:0]  s_strb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic        s_recv,
  output logic        s_ack,
  input  logic        s_error,
  input  logic [31:0] s_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_lock_id;
  logic       w_lock_id_nxt;
  logic       r_last_id;
  logic       w_sel;
  logic       w_sel_req;
  logic       w_grant;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_head_ack;
  logic       w_pop;
  ic_req_t    w_m0_fields;
  ic_req_t    w_m1_fields;
  ic_req_t    w_sel_fields;

  assign w_m0_fields = '{wen: m0_wen, strb: m0_strb, wdata: m0_wdata, addr: m0_addr};
  assign w_m1_fields = '{wen: m1_wen, strb: m1_strb, wdata: m1_wdata, addr: m1_addr};

  always_comb begin
    w_sel = IC_ID_INSTR;
    if (r_state == ST_HELD) begin
      w_sel = r_lock_id;
    end else begin
      w_sel = ic_arb_pick(m0_req, m1_req, r_last_id, PRIORITY_MODE);
    end
  end

  // Full blocks the request outright; the pop path never feeds the grant.
  assign w_sel_req    = (w_sel == IC_ID_DATA) ? m1_req : m0_req;
  assign s_req        = w_sel_req && !w_full;
  assign w_grant      = s_req && s_gnt;
  assign m0_gnt       = w_grant && (w_sel == IC_ID_INSTR);
  assign m1_gnt       = w_grant && (w_sel == IC_ID_DATA);
  assign w_sel_fields = (w_sel == IC_ID_DATA) ? w_m1_fields : w_m0_fields;
  assign s_wen        = w_sel_fields.wen;
  assign s_strb       = w_sel_fields.strb;
  assign s_wdata      = w_sel_fields.wdata;
  assign s_addr       = w_sel_fields.addr;

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    if (s_req && !s_gnt) begin
      w_state_nxt   = ST_HELD;
      w_lock_id_nxt = w_sel;
    end else if (w_grant) begin
      w_state_nxt   = ST_OPEN;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state   <= ST_OPEN;
      r_lock_id <= IC_ID_INSTR;
      r_last_id <= IC_ID_DATA;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      if (w_grant) begin
        r_last_id <= w_sel;
      end
    end
  end

  ic_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .push     (w_grant),
    .pop      (w_pop),
    .wdata    (w_sel),
    .rdata    (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Responses are routed to the queue head; a stray s_recv on empty is dropped.
  assign w_head_ack = (w_head == IC_ID_DATA) ? m1_ack : m0_ack;
  assign s_ack      = w_head_ack && !w_empty;
  assign w_pop      = s_recv && s_ack;
  assign m0_recv    = s_recv && !w_empty && (w_head == IC_ID_INSTR);
  assign m1_recv    = s_recv && !w_empty && (w_head == IC_ID_DATA);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_error   = s_error;
  assign m1_error   = s_error;

endmodule
`default_nettype wire

// File: tb/tb_ic_cpu_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module   : tb_ic_cpu_bus_arbiter
// | Brief    : Cycle-table bench with response-owner scoreboard, RR + fixed.
// | Revision : 1.0
// +----------------------------------------------------------------------------
module tb_ic_cpu_bus_arbiter;

  localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR  = 32'h0000_0200;
  localparam logic [31:0] M1_WDATA = 32'hCAFE_F00D;

  typedef struct {
    bit          r0, r1, g, rv, a0, a1;
    logic [31:0] rd;
    bit          e_g0, e_g1, e_sreq, e_sel, e_rv0, e_rv1, e_sack;
  } vec_t;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        m0_req, m0_wen, m0_ack, m1_req, m1_wen, m1_ack;
  logic [3:0]  m0_strb, m1_strb;
  logic [31:0] m0_wdata, m0_addr, m1_wdata, m1_addr;
  logic        s_gnt, s_recv, s_error;
  logic [31:0] s_rdata;

  logic        m0_gnt, m0_recv, m0_error, m1_gnt, m1_recv, m1_error;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wen, s_ack;
  logic [3:0]  s_strb;
  logic [31:0] s_wdata, s_addr;

  logic        m0_gnt_f, m0_recv_f, m0_error_f, m1_gnt_f, m1_recv_f, m1_error_f;
  logic [31:0] m0_rdata_f, m1_rdata_f;
  logic        s_req_f, s_wen_f, s_ack_f;
  logic [3:0]  s_strb_f;
  logic [31:0] s_wdata_f, s_addr_f;

  int n_cmp = 0;
  int n_bad = 0;
  bit sb [$];

  always #5 g_clk = ~g_clk;

  ic_cpu_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIORITY_MODE(0)) u_dut_rr (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_wen(m0_wen), .m0_strb(m0_strb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_recv(m0_recv), .m0_ack(m0_ack),
    .m0_error(m0_error), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_wen(m1_wen), .m1_strb(m1_strb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_recv(m1_recv), .m1_ack(m1_ack),
    .m1_error(m1_error), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_recv(s_recv), .s_ack(s_ack),
    .s_error(s_error), .s_rdata(s_rdata)
  );

  ic_cpu_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIORITY_MODE(1)) u_dut_fixed (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_gnt(m0_gnt_f), .m0_wen(m0_wen), .m0_strb(m0_strb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_recv(m0_recv_f), .m0_ack(m0_ack),
    .m0_error(m0_error_f), .m0_rdata(m0_rdata_f),
    .m1_req(m1_req), .m1_gnt(m1_gnt_f), .m1_wen(m1_wen), .m1_strb(m1_strb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_recv(m1_recv_f), .m1_ack(m1_ack),
    .m1_error(m1_error_f), .m1_rdata(m1_rdata_f),
    .s_req(s_req_f), .s_gnt(s_gnt), .s_wen(s_wen_f), .s_strb(s_strb_f),
    .s_wdata(s_wdata_f), .s_addr(s_addr_f), .s_recv(s_recv), .s_ack(s_ack_f),
    .s_error(s_error), .s_rdata(s_rdata)
  );

  // in = {r0,r1,g,rv,a0,a1}; ex = {g0,g1,sreq,sel,rv0,rv1,sack}
  function automatic vec_t mk(input bit [5:0] in, input logic [31:0] rd, input bit [6:0] ex);
    vec_t v;
    {v.r0, v.r1, v.g, v.rv, v.a0, v.a1} = in;
    v.rd = rd;
    {v.e_g0, v.e_g1, v.e_sreq, v.e_sel, v.e_rv0, v.e_rv1, v.e_sack} = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    m0_req  = v.r0;
    m1_req  = v.r1;
    s_gnt   = v.g;
    s_recv  = v.rv;
    m0_ack  = v.a0;
    m1_ack  = v.a1;
    s_rdata = v.rd;
    s_error = v.rd[0];
    if (v.e_g0) sb.push_back(1'b0);
    if (v.e_g1) sb.push_back(1'b1);
  endtask

  task automatic check_rr(input vec_t v, input string tag);
    bit exp_id;
    chk({tag, ".m0_gnt"},  32'(m0_gnt),  32'(v.e_g0));
    chk({tag, ".m1_gnt"},  32'(m1_gnt),  32'(v.e_g1));
    chk({tag, ".s_req"},   32'(s_req),   32'(v.e_sreq));
    chk({tag, ".m0_recv"}, 32'(m0_recv), 32'(v.e_rv0));
    chk({tag, ".m1_recv"}, 32'(m1_recv), 32'(v.e_rv1));
    chk({tag, ".s_ack"},   32'(s_ack),   32'(v.e_sack));
    if (v.e_sreq) begin
      chk({tag, ".s_addr"},  s_addr,          v.e_sel ? M1_ADDR : M0_ADDR);
      chk({tag, ".s_wen"},   32'(s_wen),      v.e_sel ? 32'd1 : 32'd0);
      chk({tag, ".s_strb"},  32'(s_strb),     v.e_sel ? 32'hF : 32'h0);
      chk({tag, ".s_wdata"}, s_wdata,         v.e_sel ? M1_WDATA : 32'h0);
    end
    if (v.e_rv0) begin
      chk({tag, ".m0_rdata"}, m0_rdata,        v.rd);
      chk({tag, ".m0_error"}, 32'(m0_error),   32'(v.rd[0]));
    end
    if (v.e_rv1) begin
      chk({tag, ".m1_rdata"}, m1_rdata,        v.rd);
      chk({tag, ".m1_error"}, 32'(m1_error),   32'(v.rd[0]));
    end
    if ((m0_recv && m0_ack) || (m1_recv && m1_ack)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.sb_underflow: response with no outstanding request", tag);
      end else begin
        exp_id = sb.pop_front();
        chk({tag, ".resp_owner"}, 32'(m1_recv), 32'(exp_id));
      end
    end
  endtask

  initial begin
    vec_t tbl [18];
    vec_t post [5];
    vec_t idle;
    vec_t pre;

    idle = mk(6'b000000, 32'h0, 7'b0000000);
    pre  = mk(6'b101000, 32'h0, 7'b1010000);
    // single read, RR alternation, lock under stall, queue full, head-ack hold
    tbl[0]  = mk(6'b101000, 32'h0000_0010, 7'b1010000);
    tbl[1]  = mk(6'b001110, 32'hDEAD_BEEF, 7'b0000101);
    tbl[2]  = mk(6'b111000, 32'h0000_0020, 7'b0111000);
    tbl[3]  = mk(6'b111111, 32'h0000_0031, 7'b1010011);
    tbl[4]  = mk(6'b111111, 32'h0000_0040, 7'b0111101);
    tbl[5]  = mk(6'b111111, 32'h0000_0051, 7'b1010011);
    tbl[6]  = mk(6'b000111, 32'h0000_0060, 7'b0000101);
    tbl[7]  = mk(6'b100000, 32'h0,         7'b0010000);
    tbl[8]  = mk(6'b110000, 32'h0,         7'b0010000);
    tbl[9]  = mk(6'b110000, 32'h0,         7'b0010000);
    tbl[10] = mk(6'b111000, 32'h0,         7'b1010000);
    tbl[11] = mk(6'b011000, 32'h0,         7'b0111000);
    tbl[12] = mk(6'b111000, 32'h0,         7'b0000000);
    tbl[13] = mk(6'b111111, 32'h0000_00E0, 7'b0000101);
    tbl[14] = mk(6'b000110, 32'h0000_00F1, 7'b0000010);
    tbl[15] = mk(6'b000110, 32'h0000_00F1, 7'b0000010);
    tbl[16] = mk(6'b000111, 32'h0000_0100, 7'b0000011);
    tbl[17] = mk(6'b000000, 32'h0,         7'b0000000);
    // after a mid-operation reset: first tie to m0, both queues start empty
    post[0] = mk(6'b111000, 32'h0,         7'b1010000);
    post[1] = mk(6'b111111, 32'h0000_0201, 7'b0111101);
    post[2] = mk(6'b111111, 32'h0000_0300, 7'b1010011);
    post[3] = mk(6'b111111, 32'h0000_0401, 7'b0111101);
    post[4] = mk(6'b000111, 32'h0000_0500, 7'b0000011);

    m0_wen = 1'b0; m0_strb = 4'h0; m0_wdata = 32'h0;     m0_addr = M0_ADDR;
    m1_wen = 1'b1; m1_strb = 4'hF; m1_wdata = M1_WDATA;  m1_addr = M1_ADDR;
    g_resetn = 1'b0;
    drive(idle);
    repeat (2) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;

    drive(idle);
    #4;
    check_rr(idle, "reset");
    @(posedge g_clk); #1;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      #4;
      check_rr(tbl[i], $sformatf("row%0d", i));
      @(posedge g_clk); #1;
    end

    // leave one request outstanding, then reset over it
    drive(pre);
    #4;
    check_rr(pre, "pre_reset");
    @(posedge g_clk); #1;
    g_resetn = 1'b0;
    drive(idle);
    @(posedge g_clk); #1;
    g_resetn = 1'b1;
    sb.delete();
    #4;
    check_rr(idle, "post_reset");
    chk("post_reset.fixed_gnt", 32'({m0_gnt_f, m1_gnt_f, m0_recv_f, m1_recv_f}), 32'h0);
    @(posedge g_clk); #1;

    for (int k = 0; k < 5; k++) begin
      drive(post[k]);
      #4;
      check_rr(post[k], $sformatf("post%0d", k));
      chk($sformatf("fixed%0d.m1_gnt", k),  32'(m1_gnt_f),  (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("fixed%0d.m0_gnt", k),  32'(m0_gnt_f),  32'd0);
      chk($sformatf("fixed%0d.m1_recv", k), 32'(m1_recv_f), (k >= 1) ? 32'd1 : 32'd0);
      chk($sformatf("fixed%0d.m0_recv", k), 32'(m0_recv_f), 32'd0);
      @(posedge g_clk); #1;
    end

    drive(idle);
    #4;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
